// File: rtl/ysyx_24080006_axi_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24080006_pkg / ysyx_24080006_axi_arbiter_if
// Description : AXI bundle types and the arbiter's bus interface (IFU, LSU, memory).
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_24080006_pkg;

    typedef struct packed {
        logic [31:0] araddr;
        logic        arvalid;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        rready;
    } axi_r_m2s_t;

    typedef struct packed {
        logic        arready;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rvalid;
        logic        rlast;
    } axi_r_s2m_t;

    typedef struct packed {
        logic [31:0] awaddr;
        logic        awvalid;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wvalid;
        logic        wlast;
        logic        bready;
    } axi_w_m2s_t;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic [1:0]  bresp;
        logic        bvalid;
    } axi_w_s2m_t;

endpackage

interface ysyx_24080006_axi_arbiter_if;
    import ysyx_24080006_pkg::*;

    axi_r_m2s_t ifu_r_m2s;
    axi_r_s2m_t ifu_r_s2m;
    axi_r_m2s_t lsu_r_m2s;
    axi_r_s2m_t lsu_r_s2m;
    axi_w_m2s_t lsu_w_m2s;
    axi_w_s2m_t lsu_w_s2m;
    axi_r_m2s_t mem_r_m2s;
    axi_r_s2m_t mem_r_s2m;
    axi_w_m2s_t mem_w_m2s;
    axi_w_s2m_t mem_w_s2m;

    // slave: the arbiter's view (slave to the CPU masters, master toward memory)
    modport slave (
        input  ifu_r_m2s, lsu_r_m2s, lsu_w_m2s, mem_r_s2m, mem_w_s2m,
        output ifu_r_s2m, lsu_r_s2m, lsu_w_s2m, mem_r_m2s, mem_w_m2s
    );

    // master: the surrounding system (CPU masters and the memory slave)
    modport master (
        output ifu_r_m2s, lsu_r_m2s, lsu_w_m2s, mem_r_s2m, mem_w_s2m,
        input  ifu_r_s2m, lsu_r_s2m, lsu_w_s2m, mem_r_m2s, mem_w_m2s
    );

endinterface
`default_nettype wire

// File: rtl/ysyx_24080006_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24080006_axi_arbiter
// Description : Two-master (IFU read, LSU read/write) to one-slave AXI4 arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24080006_axi_arbiter
    import ysyx_24080006_pkg::*;
(
    input  wire logic                   clock,
    input  wire logic                   reset,
    ysyx_24080006_axi_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IFU_R = 2'd1,
        ARB_LSU_R = 2'd2,
        ARB_LSU_W = 2'd3
    } arb_state_t;

    arb_state_t r_state;
    arb_state_t w_state_next;
    arb_state_t w_grant;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        // Reset forces the idle view immediately so nothing leaks out while it is held.
        w_grant      = reset ? ARB_IDLE : r_state;

        bus.mem_r_m2s = '0;
        bus.mem_w_m2s = '0;

        // Data fields are broadcast; only the handshake bits are gated per grant.
        bus.ifu_r_s2m         = bus.mem_r_s2m;
        bus.ifu_r_s2m.arready = 1'b0;
        bus.ifu_r_s2m.rvalid  = 1'b0;
        bus.lsu_r_s2m         = bus.mem_r_s2m;
        bus.lsu_r_s2m.arready = 1'b0;
        bus.lsu_r_s2m.rvalid  = 1'b0;
        bus.lsu_w_s2m         = bus.mem_w_s2m;
        bus.lsu_w_s2m.awready = 1'b0;
        bus.lsu_w_s2m.wready  = 1'b0;
        bus.lsu_w_s2m.bvalid  = 1'b0;

        unique case (w_grant)
            ARB_IFU_R: begin
                bus.mem_r_m2s = bus.ifu_r_m2s;
                bus.ifu_r_s2m = bus.mem_r_s2m;
            end
            ARB_LSU_R: begin
                bus.mem_r_m2s = bus.lsu_r_m2s;
                bus.lsu_r_s2m = bus.mem_r_s2m;
            end
            ARB_LSU_W: begin
                bus.mem_w_m2s = bus.lsu_w_m2s;
                bus.lsu_w_s2m = bus.mem_w_s2m;
            end
            default: begin
            end
        endcase

        unique case (r_state)
            ARB_IDLE: begin
                if (bus.lsu_w_m2s.awvalid) begin
                    w_state_next = ARB_LSU_W;
                end else if (bus.lsu_r_m2s.arvalid) begin
                    w_state_next = ARB_LSU_R;
                end else if (bus.ifu_r_m2s.arvalid) begin
                    w_state_next = ARB_IFU_R;
                end
            end
            ARB_IFU_R, ARB_LSU_R: begin
                // Bursts keep the grant until the last beat is accepted.
                if (bus.mem_r_s2m.rvalid && bus.mem_r_m2s.rready && bus.mem_r_s2m.rlast) begin
                    w_state_next = ARB_IDLE;
                end
            end
            ARB_LSU_W: begin
                if (bus.mem_w_s2m.bvalid && bus.lsu_w_m2s.bready) begin
                    w_state_next = ARB_IDLE;
                end
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24080006_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_24080006_axi_arbiter
// Description : Self-checking bench; TB plays both CPU masters and the memory slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_24080006_axi_arbiter;
    import ysyx_24080006_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ysyx_24080006_axi_arbiter_if bus ();

    ysyx_24080006_axi_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Every handshake bit the arbiter drives, packed for all-zero checks.
    function automatic logic [11:0] hs();
        return {bus.mem_r_m2s.arvalid, bus.mem_r_m2s.rready, bus.mem_w_m2s.awvalid,
                bus.mem_w_m2s.wvalid, bus.mem_w_m2s.bready, bus.ifu_r_s2m.arready,
                bus.ifu_r_s2m.rvalid, bus.lsu_r_s2m.arready, bus.lsu_r_s2m.rvalid,
                bus.lsu_w_s2m.awready, bus.lsu_w_s2m.wready, bus.lsu_w_s2m.bvalid};
    endfunction

    function automatic logic [31:0] beat_data(input logic [31:0] a, input int b);
        return a ^ (32'h0101_0101 * (b + 1)) ^ 32'hA5A5_0000;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_all();
        bus.ifu_r_m2s = '0;
        bus.lsu_r_m2s = '0;
        bus.lsu_w_m2s = '0;
        bus.mem_r_s2m = '0;
        bus.mem_w_s2m = '0;
    endtask

    task automatic test_reset();
        clear_all();
        reset = 1'b1;
        bus.ifu_r_m2s.arvalid = 1'b1;
        bus.lsu_w_m2s.awvalid = 1'b1;
        bus.lsu_w_m2s.bready  = 1'b1;
        bus.mem_r_s2m.arready = 1'b1;
        bus.mem_r_s2m.rvalid  = 1'b1;
        bus.mem_w_s2m.awready = 1'b1;
        bus.mem_w_s2m.bvalid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            checks++;
            if (hs() !== 12'h000) begin
                errors++;
                $display("FAIL reset_handshakes cycle %0d: got %h expected 000", i, hs());
            end
        end
        clear_all();
        step();
        reset = 1'b0;
    endtask

    task automatic test_ifu_read();
        step();
        bus.ifu_r_m2s.araddr  = 32'h3000_0000;
        bus.ifu_r_m2s.arvalid = 1'b1;
        bus.ifu_r_m2s.arburst = 2'b01;
        bus.ifu_r_m2s.rready  = 1'b1;
        #1;
        checks++;
        if (hs() !== 12'h000) begin
            errors++;
            $display("FAIL ifu_grant_latency: got %h expected 000", hs());
        end
        step();
        bus.mem_r_s2m.arready = 1'b1;
        #1;
        checks++;
        if (!(bus.mem_r_m2s.arvalid === 1'b1 && bus.mem_r_m2s.araddr === 32'h3000_0000
              && bus.ifu_r_s2m.arready === 1'b1)) begin
            errors++;
            $display("FAIL ifu_grant: got arvalid %b araddr %h arready %b expected 1 30000000 1",
                     bus.mem_r_m2s.arvalid, bus.mem_r_m2s.araddr, bus.ifu_r_s2m.arready);
        end
        step();
        bus.ifu_r_m2s.arvalid = 1'b0;
        bus.mem_r_s2m.arready = 1'b0;
        repeat (2) step();
        step();
        bus.mem_r_s2m.rvalid = 1'b1;
        bus.mem_r_s2m.rdata  = 32'hDEAD_BEEF;
        bus.mem_r_s2m.rlast  = 1'b1;
        #1;
        checks++;
        if ({bus.ifu_r_s2m.rvalid, bus.lsu_r_s2m.rvalid} !== 2'b10 || bus.ifu_r_s2m.rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL ifu_rdata: got rvalid %b%b data %h expected 10 deadbeef",
                     bus.ifu_r_s2m.rvalid, bus.lsu_r_s2m.rvalid, bus.ifu_r_s2m.rdata);
        end
        step();
        bus.mem_r_s2m.rvalid = 1'b0;
        #1;
        checks++;
        if (hs() !== 12'h000) begin
            errors++;
            $display("FAIL ifu_release: got %h expected 000", hs());
        end
        clear_all();
    endtask

    task automatic test_priority();
        step();
        bus.ifu_r_m2s.araddr  = 32'h3000_0010;
        bus.ifu_r_m2s.arvalid = 1'b1;
        bus.ifu_r_m2s.rready  = 1'b1;
        bus.lsu_r_m2s.araddr  = 32'h8000_1000;
        bus.lsu_r_m2s.arvalid = 1'b1;
        bus.lsu_r_m2s.rready  = 1'b1;
        step();
        bus.mem_r_s2m.arready = 1'b1;
        #1;
        checks++;
        if (bus.mem_r_m2s.araddr !== 32'h8000_1000 || {bus.lsu_r_s2m.arready, bus.ifu_r_s2m.arready} !== 2'b10) begin
            errors++;
            $display("FAIL prio_lsu_first: got araddr %h ready %b%b expected 80001000 10",
                     bus.mem_r_m2s.araddr, bus.lsu_r_s2m.arready, bus.ifu_r_s2m.arready);
        end
        step();
        bus.lsu_r_m2s.arvalid = 1'b0;
        bus.mem_r_s2m.arready = 1'b0;
        bus.mem_r_s2m.rvalid  = 1'b1;
        bus.mem_r_s2m.rlast   = 1'b1;
        bus.mem_r_s2m.rdata   = 32'h1111_2222;
        #1;
        checks++;
        if ({bus.lsu_r_s2m.rvalid, bus.ifu_r_s2m.rvalid, bus.ifu_r_s2m.arready} !== 3'b100) begin
            errors++;
            $display("FAIL prio_lsu_beat: got %b expected 100",
                     {bus.lsu_r_s2m.rvalid, bus.ifu_r_s2m.rvalid, bus.ifu_r_s2m.arready});
        end
        step();
        bus.mem_r_s2m.rvalid = 1'b0;
        #1;
        checks++;
        if (bus.mem_r_m2s.arvalid !== 1'b0) begin
            errors++;
            $display("FAIL prio_idle_gap: got arvalid %b expected 0", bus.mem_r_m2s.arvalid);
        end
        step();
        bus.mem_r_s2m.arready = 1'b1;
        #1;
        checks++;
        if (bus.mem_r_m2s.arvalid !== 1'b1 || bus.mem_r_m2s.araddr !== 32'h3000_0010 || bus.ifu_r_s2m.arready !== 1'b1) begin
            errors++;
            $display("FAIL prio_ifu_second: got arvalid %b araddr %h expected 1 30000010",
                     bus.mem_r_m2s.arvalid, bus.mem_r_m2s.araddr);
        end
        step();
        bus.ifu_r_m2s.arvalid = 1'b0;
        bus.mem_r_s2m.arready = 1'b0;
        bus.mem_r_s2m.rvalid  = 1'b1;
        step();
        clear_all();
        step();
    endtask

    task automatic test_lsu_write();
        step();
        bus.lsu_w_m2s.awaddr  = 32'h8000_0004;
        bus.lsu_w_m2s.awvalid = 1'b1;
        bus.lsu_w_m2s.wdata   = 32'h0000_AB00;
        bus.lsu_w_m2s.wstrb   = 4'b0010;
        bus.lsu_w_m2s.wvalid  = 1'b1;
        bus.lsu_w_m2s.wlast   = 1'b1;
        bus.lsu_r_m2s.arvalid = 1'b1;
        bus.lsu_r_m2s.araddr  = 32'h8000_2000;
        step();
        bus.mem_w_s2m.awready = 1'b1;
        bus.mem_w_s2m.wready  = 1'b1;
        #1;
        checks++;
        if (bus.mem_w_m2s.awaddr !== 32'h8000_0004 || bus.mem_w_m2s.wdata !== 32'h0000_AB00
            || bus.mem_w_m2s.wstrb !== 4'b0010 || bus.mem_w_m2s.wlast !== 1'b1
            || {bus.mem_w_m2s.awvalid, bus.mem_w_m2s.wvalid, bus.mem_r_m2s.arvalid} !== 3'b110
            || {bus.lsu_w_s2m.awready, bus.lsu_w_s2m.wready} !== 2'b11) begin
            errors++;
            $display("FAIL write_pass: got addr %h data %h strb %b v %b expected 80000004 0000ab00 0010 110",
                     bus.mem_w_m2s.awaddr, bus.mem_w_m2s.wdata, bus.mem_w_m2s.wstrb,
                     {bus.mem_w_m2s.awvalid, bus.mem_w_m2s.wvalid, bus.mem_r_m2s.arvalid});
        end
        step();
        bus.lsu_w_m2s.awvalid = 1'b0;
        bus.lsu_w_m2s.wvalid  = 1'b0;
        bus.mem_w_s2m.awready = 1'b0;
        bus.mem_w_s2m.wready  = 1'b0;
        bus.mem_w_s2m.bvalid  = 1'b1;
        bus.mem_w_s2m.bresp   = 2'b10;
        #1;
        checks++;
        if (bus.lsu_w_s2m.bvalid !== 1'b1 || bus.lsu_w_s2m.bresp !== 2'b10 || bus.mem_w_m2s.bready !== 1'b0) begin
            errors++;
            $display("FAIL write_bvalid: got bvalid %b bresp %b bready %b expected 1 10 0",
                     bus.lsu_w_s2m.bvalid, bus.lsu_w_s2m.bresp, bus.mem_w_m2s.bready);
        end
        step();
        bus.lsu_w_m2s.bready = 1'b1;
        #1;
        checks++;
        if (bus.mem_w_m2s.bready !== 1'b1 || bus.lsu_w_s2m.bvalid !== 1'b1) begin
            errors++;
            $display("FAIL write_bready: got bready %b bvalid %b expected 1 1",
                     bus.mem_w_m2s.bready, bus.lsu_w_s2m.bvalid);
        end
        step();
        bus.lsu_r_m2s.arvalid = 1'b0;
        #1;
        checks++;
        if (bus.lsu_w_s2m.bvalid !== 1'b0 || bus.mem_w_m2s.bready !== 1'b0) begin
            errors++;
            $display("FAIL write_release: got bvalid %b bready %b expected 0 0",
                     bus.lsu_w_s2m.bvalid, bus.mem_w_m2s.bready);
        end
        clear_all();
        step();
    endtask

    task automatic test_burst();
        step();
        bus.ifu_r_m2s.araddr  = 32'h3000_0100;
        bus.ifu_r_m2s.arlen   = 8'd3;
        bus.ifu_r_m2s.arburst = 2'b01;
        bus.ifu_r_m2s.arvalid = 1'b1;
        bus.ifu_r_m2s.rready  = 1'b1;
        bus.lsu_r_m2s.araddr  = 32'h8000_3000;
        bus.lsu_r_m2s.rready  = 1'b1;
        step();
        bus.mem_r_s2m.arready = 1'b1;
        #1;
        checks++;
        if (bus.mem_r_m2s.arlen !== 8'd3 || bus.mem_r_m2s.arburst !== 2'b01) begin
            errors++;
            $display("FAIL burst_fields: got arlen %0d arburst %b expected 3 01",
                     bus.mem_r_m2s.arlen, bus.mem_r_m2s.arburst);
        end
        step();
        bus.ifu_r_m2s.arvalid = 1'b0;
        bus.mem_r_s2m.arready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            step();
            bus.mem_r_s2m.rvalid = 1'b1;
            bus.mem_r_s2m.rdata  = beat_data(32'h3000_0100, b);
            bus.mem_r_s2m.rlast  = (b == 3);
            if (b == 2) bus.lsu_r_m2s.arvalid = 1'b1;
            #1;
            checks++;
            if (bus.ifu_r_s2m.rvalid !== 1'b1 || bus.ifu_r_s2m.rdata !== beat_data(32'h3000_0100, b)
                || bus.lsu_r_s2m.arready !== 1'b0 || bus.mem_r_m2s.araddr !== 32'h3000_0100) begin
                errors++;
                $display("FAIL burst_beat%0d: got rvalid %b data %h araddr %h expected 1 %h 30000100",
                         b, bus.ifu_r_s2m.rvalid, bus.ifu_r_s2m.rdata, bus.mem_r_m2s.araddr,
                         beat_data(32'h3000_0100, b));
            end
        end
        step();
        bus.mem_r_s2m.rvalid = 1'b0;
        bus.mem_r_s2m.rlast  = 1'b0;
        #1;
        checks++;
        if (hs() !== 12'h000) begin
            errors++;
            $display("FAIL burst_idle: got %h expected 000", hs());
        end
        step();
        #1;
        checks++;
        if (bus.mem_r_m2s.arvalid !== 1'b1 || bus.mem_r_m2s.araddr !== 32'h8000_3000) begin
            errors++;
            $display("FAIL burst_lsu_next: got arvalid %b araddr %h expected 1 80003000",
                     bus.mem_r_m2s.arvalid, bus.mem_r_m2s.araddr);
        end
    endtask

    // Continues from test_burst: LSU read is granted and waiting for data.
    task automatic test_reset_mid();
        bus.mem_r_s2m.arready = 1'b1;
        step();
        bus.lsu_r_m2s.arvalid = 1'b0;
        bus.mem_r_s2m.arready = 1'b0;
        step();
        reset = 1'b1;
        bus.mem_r_s2m.rvalid = 1'b1;
        bus.mem_r_s2m.rlast  = 1'b1;
        #1;
        checks++;
        if (hs() !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_same_cycle: got %h expected 000", hs());
        end
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (hs() !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_after: got %h expected 000", hs());
        end
        step();
        #1;
        checks++;
        if (bus.lsu_r_s2m.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_late_rvalid: got %b expected 0", bus.lsu_r_s2m.rvalid);
        end
        clear_all();
        step();
    endtask

    task automatic test_rready_stall();
        bus.ifu_r_m2s.araddr  = 32'h3000_0200;
        bus.ifu_r_m2s.arvalid = 1'b1;
        step();
        bus.mem_r_s2m.arready = 1'b1;
        step();
        bus.ifu_r_m2s.arvalid = 1'b0;
        bus.mem_r_s2m.arready = 1'b0;
        bus.mem_r_s2m.rvalid  = 1'b1;
        bus.mem_r_s2m.rlast   = 1'b1;
        bus.mem_r_s2m.rdata   = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (bus.ifu_r_s2m.rvalid !== 1'b1 || bus.ifu_r_s2m.rdata !== 32'h1234_5678 || bus.mem_r_m2s.rready !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle%0d: got rvalid %b data %h rready %b expected 1 12345678 0",
                         i, bus.ifu_r_s2m.rvalid, bus.ifu_r_s2m.rdata, bus.mem_r_m2s.rready);
            end
            step();
        end
        bus.ifu_r_m2s.rready = 1'b1;
        #1;
        checks++;
        if (bus.mem_r_m2s.rready !== 1'b1 || bus.ifu_r_s2m.rvalid !== 1'b1) begin
            errors++;
            $display("FAIL stall_accept: got rready %b rvalid %b expected 1 1",
                     bus.mem_r_m2s.rready, bus.ifu_r_s2m.rvalid);
        end
        step();
        #1;
        checks++;
        if (bus.mem_r_m2s.rready !== 1'b0 || bus.ifu_r_s2m.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: got rready %b rvalid %b expected 0 0",
                     bus.mem_r_m2s.rready, bus.ifu_r_s2m.rvalid);
        end
        clear_all();
        step();
    endtask

    // Random simultaneous requests; service order follows LSU-W > LSU-R > IFU-R.
    task automatic test_random();
        for (int round = 0; round < 30; round++) begin
            logic [2:0]  req;
            logic [31:0] addr [3];
            int          len  [3];
            int          order [$];
            req = 3'($urandom_range(1, 7));
            for (int k = 0; k < 3; k++) begin
                addr[k] = $urandom & 32'hFFFF_FFFC;
                len[k]  = $urandom_range(0, 2);
                if (req[k]) order.push_back(k);
            end
            bus.lsu_w_m2s = '{awaddr: addr[0], awvalid: req[0], awlen: 8'd0, awsize: 3'd2, awburst: 2'b01,
                              wdata: ~addr[0], wstrb: 4'hF, wvalid: req[0], wlast: 1'b1, bready: 1'b1};
            bus.lsu_r_m2s = '{araddr: addr[1], arvalid: req[1], arlen: 8'(len[1]), arsize: 3'd2,
                              arburst: 2'b01, rready: 1'b1};
            bus.ifu_r_m2s = '{araddr: addr[2], arvalid: req[2], arlen: 8'(len[2]), arsize: 3'd2,
                              arburst: 2'b01, rready: 1'b1};
            while (order.size() > 0) begin
                int          k;
                int          n;
                logic [31:0] gaddr;
                logic        gkind;
                k = order.pop_front();
                n = 0;
                #1;
                while (!(bus.mem_r_m2s.arvalid || bus.mem_w_m2s.awvalid) && n < 8) begin
                    step();
                    #1;
                    n++;
                end
                gaddr = (k == 0) ? bus.mem_w_m2s.awaddr : bus.mem_r_m2s.araddr;
                gkind = (k == 0) ? (bus.mem_w_m2s.awvalid && !bus.mem_r_m2s.arvalid)
                                 : (bus.mem_r_m2s.arvalid && !bus.mem_w_m2s.awvalid);
                checks++;
                if (n == 8 || !gkind || gaddr !== addr[k]) begin
                    errors++;
                    $display("FAIL rand_grant round %0d: got addr %h kind_ok %b wait %0d expected master %0d addr %h",
                             round, gaddr, gkind, n, k, addr[k]);
                    clear_all();
                    reset = 1'b1;
                    step();
                    reset = 1'b0;
                    return;
                end
                step();
                bus.mem_r_s2m.arready = 1'b1;
                bus.mem_w_s2m.awready = 1'b1;
                bus.mem_w_s2m.wready  = 1'b1;
                #1;
                checks++;
                if ({bus.ifu_r_s2m.arready, bus.lsu_r_s2m.arready, bus.lsu_w_s2m.awready} !== (3'b001 << k)) begin
                    errors++;
                    $display("FAIL rand_ready round %0d: got %b expected %b", round,
                             {bus.ifu_r_s2m.arready, bus.lsu_r_s2m.arready, bus.lsu_w_s2m.awready}, 3'b001 << k);
                end
                step();
                bus.mem_r_s2m.arready = 1'b0;
                bus.mem_w_s2m.awready = 1'b0;
                bus.mem_w_s2m.wready  = 1'b0;
                if (k == 0) begin
                    bus.lsu_w_m2s.awvalid = 1'b0;
                    bus.lsu_w_m2s.wvalid  = 1'b0;
                end else if (k == 1) begin
                    bus.lsu_r_m2s.arvalid = 1'b0;
                end else begin
                    bus.ifu_r_m2s.arvalid = 1'b0;
                end
                repeat ($urandom_range(0, 2)) step();
                if (k == 0) begin
                    logic [1:0] resp;
                    resp = 2'($urandom_range(0, 3));
                    bus.mem_w_s2m.bvalid = 1'b1;
                    bus.mem_w_s2m.bresp  = resp;
                    #1;
                    checks++;
                    if (bus.lsu_w_s2m.bvalid !== 1'b1 || bus.lsu_w_s2m.bresp !== resp) begin
                        errors++;
                        $display("FAIL rand_bresp round %0d: got %b %b expected 1 %b",
                                 round, bus.lsu_w_s2m.bvalid, bus.lsu_w_s2m.bresp, resp);
                    end
                    step();
                    bus.mem_w_s2m.bvalid = 1'b0;
                end else begin
                    for (int b = 0; b <= len[k]; b++) begin
                        bus.mem_r_s2m.rvalid = 1'b1;
                        bus.mem_r_s2m.rdata  = beat_data(addr[k], b);
                        bus.mem_r_s2m.rlast  = (b == len[k]);
                        #1;
                        checks++;
                        if ({bus.ifu_r_s2m.rvalid, bus.lsu_r_s2m.rvalid} !== ((k == 1) ? 2'b01 : 2'b10)
                            || ((k == 1) ? bus.lsu_r_s2m.rdata : bus.ifu_r_s2m.rdata) !== beat_data(addr[k], b)) begin
                            errors++;
                            $display("FAIL rand_beat round %0d beat %0d: got rvalid %b%b expected master %0d data %h",
                                     round, b, bus.ifu_r_s2m.rvalid, bus.lsu_r_s2m.rvalid, k, beat_data(addr[k], b));
                        end
                        step();
                    end
                    bus.mem_r_s2m.rvalid = 1'b0;
                    bus.mem_r_s2m.rlast  = 1'b0;
                end
            end
            #1;
            checks++;
            if (hs() !== 12'h000) begin
                errors++;
                $display("FAIL rand_end_idle round %0d: got %h expected 000", round, hs());
            end
            clear_all();
            step();
        end
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_priority();
        test_lsu_write();
        test_burst();
        test_reset_mid();
        test_rready_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
